// File: rtl/mux_reg_pipe.sv
// mux_reg_pipe
// Tapped register delay line with an output mux. Data enters stage 0 on
// every clock-enabled edge and moves one stage deeper per enabled edge.
// The output either bypasses the chain (SEL=0) or reads the stage picked
// by TAP (SEL=1). A TAP value past the last stage reads the last stage.
//
// Parameters
//   WIDTH  data width, 1..48
//   DEPTH  number of stages, 1..8 (FILL is 4 bits wide)
//   TW     width of TAP, 2**TW >= DEPTH
//
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-low reset, clears data and valid bits
//   CE       enable for the whole chain
//   SEL      0: OUT follows D combinationally, 1: OUT reads stage TAP
//   FLUSH    clears all valid bits, data registers hold
//   TAP      stage index used when SEL=1
//   D/D_VLD  data in and its qualifier
//   OUT/OUT_VLD  selected data and its qualifier
//   FILL     number of stages holding valid data
module mux_reg_pipe #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  parameter int TW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             CE,
  input  logic             SEL,
  input  logic             FLUSH,
  input  logic [TW-1:0]    TAP,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VLD,
  output logic [WIDTH-1:0] OUT,
  output logic             OUT_VLD,
  output logic [3:0]       FILL
);

  logic [DEPTH-1:0][WIDTH-1:0] stg;
  logic [DEPTH-1:0]            vld;

  // Values each stage takes on a shifting edge.
  logic [DEPTH-1:0][WIDTH-1:0] stg_sh;
  logic [DEPTH-1:0]            vld_sh;

  assign stg_sh[0] = D;
  assign vld_sh[0] = D_VLD;

  for (genvar g = 1; g < DEPTH; g++) begin : g_shift
    assign stg_sh[g] = stg[g-1];
    assign vld_sh[g] = vld[g-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stg <= '0;
      vld <= '0;
    end else if (FLUSH) begin
      // Data is left in place; only the qualifiers are dropped, and the
      // word presented on this edge is not captured.
      vld <= '0;
    end else if (CE) begin
      stg <= stg_sh;
      vld <= vld_sh;
    end
  end

  // Out-of-range taps read the deepest stage.
  logic [TW-1:0] tap_c;
  assign tap_c = (TAP > TW'(DEPTH - 1)) ? TW'(DEPTH - 1) : TAP;

  // Priority-free select: exactly one stage matches the clamped tap, so a
  // chain of 2:1 muxes seeded with zero yields that stage.
  logic [DEPTH:0][WIDTH-1:0] sel_d;
  logic [DEPTH:0]            sel_v;

  assign sel_d[0] = '0;
  assign sel_v[0] = 1'b0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_tap
    assign sel_d[g+1] = (tap_c == TW'(g)) ? stg[g] : sel_d[g];
    assign sel_v[g+1] = (tap_c == TW'(g)) ? vld[g] : sel_v[g];
  end

  assign OUT     = SEL ? sel_d[DEPTH] : D;
  assign OUT_VLD = SEL ? sel_v[DEPTH] : D_VLD;

  // Population count of the valid bits.
  logic [DEPTH:0][3:0] fill_acc;

  assign fill_acc[0] = 4'd0;

  for (genvar g = 0; g < DEPTH; g++) begin : g_fill
    assign fill_acc[g+1] = fill_acc[g] + {3'b000, vld[g]};
  end

  assign FILL = fill_acc[DEPTH];

endmodule

// File: tb/tb_mux_reg_pipe.sv
module tb_mux_reg_pipe;

  logic        clk = 1'b0;
  logic        rst, CE, SEL, FLUSH, D_VLD;
  logic [2:0]  TAP;
  logic [17:0] D;
  logic [17:0] OUT;
  logic        OUT_VLD;
  logic [3:0]  FILL;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: index 0 is the most recently captured word.
  logic [17:0] q_d[$];
  logic        q_v[$];

  mux_reg_pipe #(.WIDTH(18), .DEPTH(4), .TW(3)) dut (
    .clk(clk), .rst(rst), .CE(CE), .SEL(SEL), .FLUSH(FLUSH), .TAP(TAP),
    .D(D), .D_VLD(D_VLD), .OUT(OUT), .OUT_VLD(OUT_VLD), .FILL(FILL)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      foreach (q_d[i]) begin q_d[i] = '0; q_v[i] = 1'b0; end
    end else if (FLUSH) begin
      foreach (q_v[i]) q_v[i] = 1'b0;
    end else if (CE) begin
      q_d.push_front(D);
      q_v.push_front(D_VLD);
      void'(q_d.pop_back());
      void'(q_v.pop_back());
    end
    #1;
  endtask

  function automatic int m_tap();
    return (TAP < 3'd4) ? int'(TAP) : 3;
  endfunction

  function automatic logic [17:0] m_out();
    return SEL ? q_d[m_tap()] : D;
  endfunction

  function automatic logic m_vld();
    return SEL ? q_v[m_tap()] : D_VLD;
  endfunction

  function automatic logic [3:0] m_fill();
    int c = 0;
    foreach (q_v[i]) c += int'(q_v[i]);
    return 4'(c);
  endfunction

  task automatic do_reset();
    rst = 1'b0; CE = 1'b1; FLUSH = 1'b0; D_VLD = 1'b1; D = 18'(($urandom));
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; CE = 1'b1; FLUSH = 1'b1; SEL = 1'b1; TAP = 3'd0;
    D = 18'h1234; D_VLD = 1'b1;
    tick();
    tick();
    for (int t = 0; t < 4; t++) begin
      TAP = 3'(t); #1;
      n_cmp++;
      if (OUT !== 18'h0 || OUT_VLD !== 1'b0 || FILL !== 4'd0) begin
        n_err++;
        $display("FAIL reset_sel1 tap=%0d: got OUT=%h VLD=%b FILL=%0d, want 0/0/0",
                 t, OUT, OUT_VLD, FILL);
      end
    end
    SEL = 1'b0; D = 18'h2A5A5; D_VLD = 1'b1; #1;
    n_cmp++;
    if (OUT !== 18'h2A5A5 || OUT_VLD !== 1'b1 || FILL !== 4'd0) begin
      n_err++;
      $display("FAIL reset_sel0: got OUT=%h VLD=%b FILL=%0d, want 2a5a5/1/0",
               OUT, OUT_VLD, FILL);
    end
    rst = 1'b1; FLUSH = 1'b0;
  endtask

  task automatic test_fill();
    logic [17:0] e_out[5]  = '{18'd0, 18'd0, 18'd0, 18'd1, 18'd2};
    logic        e_vld[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [3:0]  e_fill[5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4};
    do_reset();
    SEL = 1'b1; TAP = 3'd3; CE = 1'b1; D_VLD = 1'b1; FLUSH = 1'b0;
    for (int i = 0; i < 5; i++) begin
      D = 18'(i + 1);
      tick();
      n_cmp++;
      if (OUT !== e_out[i] || OUT_VLD !== e_vld[i] || FILL !== e_fill[i]) begin
        n_err++;
        $display("FAIL fill edge%0d: got OUT=%h VLD=%b FILL=%0d, want %h/%b/%0d",
                 i + 1, OUT, OUT_VLD, FILL, e_out[i], e_vld[i], e_fill[i]);
      end
    end
  endtask

  task automatic test_tap_sweep();
    do_reset();
    SEL = 1'b1; CE = 1'b1; D_VLD = 1'b1;
    for (int i = 0; i < 4; i++) begin D = 18'h11 + 18'(i); tick(); end
    CE = 1'b0;
    for (int t = 0; t < 4; t++) begin
      TAP = 3'(t); D = 18'(($urandom)); D_VLD = 1'($urandom);
      tick();
      n_cmp++;
      if (OUT !== 18'h14 - 18'(t) || OUT_VLD !== 1'b1 || FILL !== 4'd4) begin
        n_err++;
        $display("FAIL tap_sweep tap=%0d: got OUT=%h VLD=%b FILL=%0d, want %h/1/4",
                 t, OUT, OUT_VLD, FILL, 18'h14 - 18'(t));
      end
    end
    TAP = 3'd7; #1;
    n_cmp++;
    if (OUT !== 18'h11 || OUT_VLD !== 1'b1) begin
      n_err++;
      $display("FAIL tap_clamp: got OUT=%h VLD=%b, want 00011/1", OUT, OUT_VLD);
    end
  endtask

  task automatic test_bypass();
    SEL = 1'b0; CE = 1'b1; D = 18'h3FFFF; D_VLD = 1'b1; #1;
    n_cmp++;
    if (OUT !== 18'h3FFFF || OUT_VLD !== 1'b1) begin
      n_err++;
      $display("FAIL bypass_comb: got OUT=%h VLD=%b, want 3ffff/1", OUT, OUT_VLD);
    end
    tick();
    SEL = 1'b1; TAP = 3'd0; D = 18'h0; D_VLD = 1'b0; #1;
    n_cmp++;
    if (OUT !== 18'h3FFFF || OUT_VLD !== 1'b1) begin
      n_err++;
      $display("FAIL bypass_shift: got OUT=%h VLD=%b, want 3ffff/1", OUT, OUT_VLD);
    end
  endtask

  // Chain on entry: 3ffff, 14, 13, 12, all valid.
  task automatic test_ce_hold();
    SEL = 1'b1; TAP = 3'd1; CE = 1'b0;
    for (int i = 0; i < 5; i++) begin
      D = 18'(($urandom)); D_VLD = 1'b1;
      tick();
      n_cmp++;
      if (OUT !== 18'h14 || FILL !== 4'd4) begin
        n_err++;
        $display("FAIL ce_hold edge%0d: got OUT=%h FILL=%0d, want 00014/4",
                 i, OUT, FILL);
      end
    end
    CE = 1'b1; D_VLD = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (FILL !== 4'(3 - i)) begin
        n_err++;
        $display("FAIL ce_drain edge%0d: got FILL=%0d, want %0d", i, FILL, 3 - i);
      end
    end
  endtask

  task automatic test_flush();
    SEL = 1'b1; TAP = 3'd0; CE = 1'b1; D_VLD = 1'b1;
    for (int i = 0; i < 4; i++) begin D = 18'h100 + 18'(i); tick(); end
    FLUSH = 1'b1; D = 18'h00ABC;
    tick();
    FLUSH = 1'b0; CE = 1'b0;
    n_cmp++;
    if (FILL !== 4'd0 || OUT_VLD !== 1'b0 || OUT !== 18'h103) begin
      n_err++;
      $display("FAIL flush: got OUT=%h VLD=%b FILL=%0d, want 00103/0/0",
               OUT, OUT_VLD, FILL);
    end
  endtask

  task automatic test_reset_mid();
    SEL = 1'b1; CE = 1'b1; D_VLD = 1'b1;
    for (int i = 0; i < 4; i++) begin D = 18'h200 + 18'(i); tick(); end
    rst = 1'b0; FLUSH = 1'b1;
    tick();
    rst = 1'b1; FLUSH = 1'b0;
    for (int t = 0; t < 4; t++) begin
      TAP = 3'(t); #1;
      n_cmp++;
      if (OUT !== 18'h0 || FILL !== 4'd0) begin
        n_err++;
        $display("FAIL reset_mid tap=%0d: got OUT=%h FILL=%0d, want 0/0", t, OUT, FILL);
      end
    end
    D = 18'h5; D_VLD = 1'b1; CE = 1'b1;
    tick();
    TAP = 3'd0; #1;
    n_cmp++;
    if (OUT !== 18'h5 || OUT_VLD !== 1'b1 || FILL !== 4'd1) begin
      n_err++;
      $display("FAIL reset_release: got OUT=%h VLD=%b FILL=%0d, want 00005/1/1",
               OUT, OUT_VLD, FILL);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 39) != 0);
      FLUSH = ($urandom_range(0, 15) == 0);
      CE    = 1'($urandom);
      SEL   = 1'($urandom);
      TAP   = 3'($urandom);
      D     = 18'(($urandom));
      D_VLD = 1'($urandom);
      #1;
      n_cmp++;
      if (OUT !== m_out() || OUT_VLD !== m_vld() || FILL !== m_fill()) begin
        n_err++;
        $display("FAIL random cyc%0d sel=%b tap=%0d: got OUT=%h VLD=%b FILL=%0d, want %h/%b/%0d",
                 i, SEL, TAP, OUT, OUT_VLD, FILL, m_out(), m_vld(), m_fill());
      end
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin q_d.push_back('0); q_v.push_back(1'b0); end
    rst = 1'b0; CE = 1'b0; SEL = 1'b1; FLUSH = 1'b0; TAP = '0; D = '0; D_VLD = 1'b0;
    test_reset();
    test_fill();
    test_tap_sweep();
    test_bypass();
    test_ce_hold();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_reg_pipe.md
MUX_REG_PIPE -- requirements
Module: mux_reg_pipe

Interface
REQ-001 Parameter WIDTH, default 18: data width in bits, legal range 1..48.
REQ-002 Parameter DEPTH, default 4: number of register stages, legal range 1..8.
REQ-003 Parameter TW, default 3: width of TAP, SHALL satisfy 2^TW >= DEPTH.
REQ-004 Port clk  input  1: single clock, all state updates on rising edge.
REQ-005 Port rst  input  1: reset, synchronous, active-low.
REQ-006 Port CE  input  1: clock enable for the whole stage chain.
REQ-007 Port SEL  input  1: 0 = combinational bypass, 1 = registered (tapped) path.
REQ-008 Port FLUSH  input  1: synchronous clear of all valid bits.
REQ-009 Port TAP  input  TW: stage index driven to OUT when SEL=1.
REQ-010 Port D  input  WIDTH: data in.
REQ-011 Port D_VLD  input  1: qualifier for D.
REQ-012 Port OUT  output  WIDTH: selected data.
REQ-013 Port OUT_VLD  output  1: qualifier for OUT.
REQ-014 Port FILL  output  4: count of stages currently holding valid data.

Function
REQ-015 The block SHALL hold DEPTH data registers stg[0..DEPTH-1] of WIDTH bits plus DEPTH valid bits vld[0..DEPTH-1].
REQ-016 Priority at each rising edge SHALL be: reset > FLUSH > CE > hold.
REQ-017 With rst=1, FLUSH=0, CE=1: stg[0]<=D, vld[0]<=D_VLD, stg[k]<=stg[k-1], vld[k]<=vld[k-1] for k=1..DEPTH-1.
REQ-018 With rst=1, FLUSH=0, CE=0: all stg and vld SHALL hold.
REQ-019 With rst=1, FLUSH=1: all vld SHALL clear to 0, stg SHALL hold, regardless of CE; D and D_VLD on that edge SHALL be discarded.
REQ-020 The chain SHALL shift per REQ-017 regardless of SEL; SEL affects only the output mux.
REQ-021 SEL=0: OUT=D, OUT_VLD=D_VLD, combinationally, zero latency.
REQ-022 SEL=1: OUT=stg[t], OUT_VLD=vld[t], where t=TAP if TAP<DEPTH, else t=DEPTH-1 (clamp).
REQ-023 SEL=1 latency from D to OUT SHALL be t+1 CE-enabled edges; edges with CE=0 SHALL not count.
REQ-024 TAP and SEL changes SHALL take effect combinationally with no pipeline disturbance.
REQ-025 FILL SHALL equal the population count of vld[0..DEPTH-1], range 0..DEPTH, upper bits zero.
REQ-026 OUT, OUT_VLD and FILL SHALL be glitch-free functions of registered state when SEL=1 and TAP is static.

Reset
REQ-027 rst=0 at a rising edge SHALL clear every stg to 0 and every vld to 0, overriding CE and FLUSH.
REQ-028 After reset with SEL=1: OUT=0, OUT_VLD=0, FILL=0; with SEL=0: OUT=D, OUT_VLD=D_VLD, FILL=0.
REQ-029 Reset asserted mid-stream SHALL discard all in-flight data; the edge after release SHALL load D normally.

Verification (WIDTH=18, DEPTH=4, TW=3)
REQ-030 Reset then SEL=1, TAP=3, CE=1, D_VLD=1, D=1,2,3,4,5 on successive edges -> OUT=0,OUT_VLD=0 for first 3 edges, then OUT=1 after the 4th edge, 2 after the 5th; FILL=1,2,3,4,4.
REQ-031 Chain filled with 0x00011..0x00014 (stg[0]=0x00014), TAP swept 0..3 with CE=0 -> OUT=0x00014,0x00013,0x00012,0x00011 with no state change; TAP=7 -> OUT=0x00011 (clamp).
REQ-032 SEL=0, D=0x3FFFF, D_VLD=1 -> OUT=0x3FFFF, OUT_VLD=1 same cycle; chain still shifts (SEL back to 1, TAP=0 -> OUT=0x3FFFF after that edge).
REQ-033 Full chain (FILL=4), CE=0 for 5 edges with changing D -> OUT, FILL unchanged; CE=1 with D_VLD=0 for 2 edges -> FILL=3 then 2.
REQ-034 Full chain, FLUSH=1 and CE=1 on one edge, D=0x00ABC -> FILL=0, OUT_VLD=0, OUT (TAP=0) retains prior stg[0], 0x00ABC not captured.
REQ-035 Full chain, rst=0 with CE=1 and FLUSH=1 on one edge -> all stg=0, FILL=0; next edge with rst=1, CE=1, D=0x00005, D_VLD=1 -> TAP=0 gives OUT=0x00005, FILL=1.
